cp0_exc_unit: RTL and testbench
===============================

// Module: cp0_exc_unit
// PURPOSE
//   Parametrised coprocessor-0 for the pipelined MIPS core: holds SR, Cause, EPC, PRId, Count, Compare.
//   Samples NUM_HWINT external interrupt lines plus an optional internal timer, arbitrates
//   interrupt vs. exception and raises req to flush the pipeline.
//   On req it atomically captures EPC/BD/ExcCode and sets EXL; on eret it clears EXL.
//   Sits beside the M stage. The M stage supplies vpc, bd_in, exc_code_in, mtc0 and eret.
// PARAMETERS
//   NUM_HWINT   6              number of hardware interrupt lines, 1..6; maps to IP/IM bits [10+NUM_HWINT-1:10]
//   TIMER_EN    1              1: Count/Compare timer present; 0: regs 9/11 read 0, writes ignored
//   PRID_VAL    32'h0000_4A01  constant value returned by PRId (reg 15)
// PORTS
//   clk          in   1          clock, all state on rising edge
//   reset        in   1          synchronous, active-high
//   we           in   1          mtc0 write enable (M stage)
//   addr         in   5          CP0 register number for read and write
//   wdata        in   32         mtc0 write data
//   rdata        out  32         combinational read of reg[addr]; unimplemented regs read 0
//   vpc          in   32         PC of the M-stage (victim) instruction
//   bd_in        in   1          victim is in a branch delay slot
//   exc_code_in  in   5          exception code of the victim; 0 = none
//   hwint        in   NUM_HWINT  level-sensitive external interrupt requests
//   eret         in   1          eret in M stage
//   req          out  1          take exception/interrupt this cycle (combinational)
//   epc_out      out  32         current EPC, used as the eret target
// BEHAVIOUR
//   - Reset: SR, Cause, EPC, Count = 0; Compare = 0. Outputs after reset: req = 0, epc_out = 0.
//   - SR fields: IM = SR[10+NUM_HWINT-1:10], EXL = SR[1], IE = SR[0]. Other SR bits are hardwired 0.
//   - Cause fields: BD = [31], TI = [30], IP = [10+NUM_HWINT-1:10], ExcCode = [6:2]. Others 0.
//   - Cause.IP is updated every cycle with hwint | (timer_irq << (NUM_HWINT-1)).
//     The timer shares the highest line.
//   - int_req = |(IP_next & IM) & IE & ~EXL, where IP_next is the live value, not the registered one.
//   - exc_req = (exc_code_in != 0) & ~EXL. req = int_req | exc_req.
//   - Priority: interrupt over exception. On req at the clock edge:
//       - EXL <= 1
//       - BD <= bd_in
//       - ExcCode <= int_req ? 0 : exc_code_in
//       - EPC <= bd_in ? vpc-4 : vpc, with EPC[1:0] kept as computed
//   - mtc0 (we & ~req) writes:
//       - reg 12: IM/EXL/IE bits only
//       - reg 14: EPC, full 32 bits
//       - reg 9: Count
//       - reg 11: Compare, and also clears TI
//       - Cause is read-only; writes to 13 are ignored.
//   - req and we in the same cycle: req wins and the write is discarded.
//   - eret: EXL <= 0 at the next edge. If eret and req occur in the same cycle, eret is ignored.
//     req cannot occur when EXL = 1, so in practice this only arises with EXL = 0.
//   - eret with EXL = 0 has no effect.
//   - Timer (TIMER_EN = 1):
//       - Count increments every cycle, wrapping 32'hFFFF_FFFF -> 0.
//       - A mtc0 write to Count takes priority over the increment.
//       - TI sets the cycle after Count == Compare with Compare != 0, and is sticky.
//       - timer_irq = TI.
//   - rdata reflects register state before the current edge; no write-through forwarding.
//   - Reset during EXL = 1 returns everything to reset values; pending hwint is re-evaluated next cycle.
// TESTING
//   1. SR = 32'h0000_0401 (IM0, IE), hwint = 1 at vpc = 0x3008, bd_in = 0:
//      -> req = 1 the same cycle; next cycle EPC = 0x3008, ExcCode = 0, EXL = 1, req = 0.
//   2. exc_code_in = 10 (RI) with bd_in = 1, vpc = 0x3010, SR = 0:
//      -> req = 1; EPC = 0x300C, BD = 1, ExcCode = 10. IE = 0 does not block exceptions.
//   3. Simultaneous: hwint enabled and exc_code_in = 4 at the same time:
//      -> ExcCode = 0 (interrupt wins); also in this cycle, we = 1 to reg 14 is dropped.
//   4. With EXL = 1, raise hwint and exc_code_in = 12 -> req stays 0.
//      Then eret -> EXL = 0, and req asserts the following cycle if hwint is still high.
//   5. Timer: write Compare = 5 and Count = 0, IM top bit set, IE = 1 -> TI = 1 and req = 1 ~6 cycles later.
//      Then write Compare = 100 -> TI clears.
//   6. Mid-operation reset with EXL = 1 and Count = 0x1234 -> all registers 0, req = 0, rdata(12) = 0.

Source files
------------

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 for the pipelined MIPS core: SR, Cause, EPC, PRId, Count, Compare.
// Arbitrates interrupts over exceptions next to the M stage and raises req to flush the pipe.
module cp0_exc_unit #(
    parameter int unsigned NUM_HWINT = 6,
    parameter bit          TIMER_EN  = 1'b1,
    parameter logic [31:0] PRID_VAL  = 32'h0000_4A01
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [4:0]           addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    input  logic [31:0]          vpc,
    input  logic                 bd_in,
    input  logic [4:0]           exc_code_in,
    input  logic [NUM_HWINT-1:0] hwint,
    input  logic                 eret,
    output logic                 req,
    output logic [31:0]          epc_out
);

    localparam int unsigned IP_LSB    = 10;
    localparam logic [4:0]  REG_COUNT = 5'd9;
    localparam logic [4:0]  REG_CMP   = 5'd11;
    localparam logic [4:0]  REG_SR    = 5'd12;
    localparam logic [4:0]  REG_CAUSE = 5'd13;
    localparam logic [4:0]  REG_EPC   = 5'd14;
    localparam logic [4:0]  REG_PRID  = 5'd15;

    logic [NUM_HWINT-1:0] im_q, im_d;
    logic [NUM_HWINT-1:0] ip_q, ip_d;
    logic                 exl_q, exl_d;
    logic                 ie_q, ie_d;
    logic                 bd_q, bd_d;
    logic                 ti_q, ti_d;
    logic [4:0]           exc_code_q, exc_code_d;
    logic [31:0]          epc_q, epc_d;
    logic [31:0]          count_q, count_d;
    logic [31:0]          compare_q, compare_d;

    logic [NUM_HWINT-1:0] timer_vec;
    logic                 int_req;
    logic                 exc_req;
    logic                 mtc0;

    // Live interrupt pending vector and interrupt/exception arbitration
    always_comb begin
        timer_vec                = '0;
        timer_vec[NUM_HWINT-1]   = ti_q;
        ip_d    = hwint | timer_vec;
        int_req = (|(ip_d & im_q)) & ie_q & ~exl_q;
        exc_req = (exc_code_in != 5'd0) & ~exl_q;
        req     = int_req | exc_req;
        mtc0    = we & ~req;
    end

    // Next-state for SR/Cause/EPC and the timer
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        count_d    = count_q;
        compare_d  = compare_q;
        ti_d       = ti_q;

        if (req) begin
            exl_d      = 1'b1;
            bd_d       = bd_in;
            exc_code_d = int_req ? 5'd0 : exc_code_in;
            epc_d      = bd_in ? 32'(vpc - 32'd4) : vpc;
        end else begin
            if (mtc0 && addr == REG_SR) begin
                im_d  = wdata[IP_LSB +: NUM_HWINT];
                exl_d = wdata[1];
                ie_d  = wdata[0];
            end
            if (mtc0 && addr == REG_EPC) begin
                epc_d = wdata;
            end
            // eret only ever clears EXL, so a stale EXL=0 eret is harmless
            if (eret) begin
                exl_d = 1'b0;
            end
        end

        if (TIMER_EN) begin
            count_d = 32'(count_q + 32'd1);
            if (mtc0 && addr == REG_COUNT) begin
                count_d = wdata;
            end
            if (mtc0 && addr == REG_CMP) begin
                compare_d = wdata;
                ti_d      = 1'b0;
            end else if (count_q == compare_q && compare_q != 32'd0) begin
                ti_d = 1'b1;
            end
        end else begin
            count_d   = '0;
            compare_d = '0;
            ti_d      = 1'b0;
        end
    end

    // Register read mux; reflects pre-edge state only
    always_comb begin
        rdata = '0;
        case (addr)
            REG_COUNT: rdata = count_q;
            REG_CMP:   rdata = compare_q;
            REG_SR: begin
                rdata[IP_LSB +: NUM_HWINT] = im_q;
                rdata[1]                   = exl_q;
                rdata[0]                   = ie_q;
            end
            REG_CAUSE: begin
                rdata[31]                  = bd_q;
                rdata[30]                  = ti_q;
                rdata[IP_LSB +: NUM_HWINT] = ip_q;
                rdata[6:2]                 = exc_code_q;
            end
            REG_EPC:   rdata = epc_q;
            REG_PRID:  rdata = PRID_VAL;
            default:   rdata = '0;
        endcase
    end

    assign epc_out = epc_q;

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= '0;
            ip_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            exc_code_q <= '0;
            epc_q      <= '0;
            count_q    <= '0;
            compare_q  <= '0;
        end else begin
            im_q       <= im_d;
            ip_q       <= ip_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
        end
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit: interrupts, exceptions, eret, timer and reset.
module tb_cp0_exc_unit;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hwint;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;

    int errors = 0;
    int checks = 0;

    cp0_exc_unit #(
        .NUM_HWINT(6),
        .TIMER_EN (1'b1),
        .PRID_VAL (32'h0000_4A01)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .vpc        (vpc),
        .bd_in      (bd_in),
        .exc_code_in(exc_code_in),
        .hwint      (hwint),
        .eret       (eret),
        .req        (req),
        .epc_out    (epc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mtc0 for one cycle; returns 1 time unit after the edge
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rdata;
    endtask

    task automatic pulse_eret();
        eret = 1'b1;
        @(posedge clk);
        #1;
        eret = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", req); end
        checks++;
        if (epc_out !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h expected 00000000", epc_out); end
        rd(5'd12, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_sr: got %h expected 00000000", v); end
        rd(5'd13, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_cause: got %h expected 00000000", v); end
        rd(5'd9, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_count: got %h expected 00000000", v); end
        rd(5'd15, v);
        checks++;
        if (v !== 32'h0000_4A01) begin errors++; $display("FAIL prid: got %h expected 00004a01", v); end
        rd(5'd3, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL unimpl_reg: got %h expected 00000000", v); end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_interrupt();
        logic [31:0] v;
        wr(5'd12, 32'h0000_0401);
        hwint = 6'd1;
        vpc   = 32'h3008;
        bd_in = 1'b0;
        #1;
        checks++;
        if (req !== 1'b1) begin errors++; $display("FAIL int_req: got %b expected 1", req); end
        @(posedge clk);
        #1;
        checks++;
        if (epc_out !== 32'h3008) begin errors++; $display("FAIL int_epc: got %h expected 00003008", epc_out); end
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL int_req_after: got %b expected 0", req); end
        rd(5'd13, v);
        checks++;
        if (v !== 32'h0000_0400) begin errors++; $display("FAIL int_cause: got %h expected 00000400", v); end
        rd(5'd12, v);
        checks++;
        if (v !== 32'h0000_0403) begin errors++; $display("FAIL int_sr_exl: got %h expected 00000403", v); end
        hwint = 6'd0;
        pulse_eret();
        rd(5'd12, v);
        checks++;
        if (v !== 32'h0000_0401) begin errors++; $display("FAIL int_eret_sr: got %h expected 00000401", v); end
    endtask

    task automatic test_exception();
        logic [31:0] v;
        wr(5'd12, 32'h0);
        exc_code_in = 5'd10;
        bd_in       = 1'b1;
        vpc         = 32'h3010;
        #1;
        checks++;
        if (req !== 1'b1) begin errors++; $display("FAIL exc_req: got %b expected 1", req); end
        @(posedge clk);
        #1;
        exc_code_in = 5'd0;
        bd_in       = 1'b0;
        checks++;
        if (epc_out !== 32'h300C) begin errors++; $display("FAIL exc_epc_bd: got %h expected 0000300c", epc_out); end
        rd(5'd13, v);
        checks++;
        if (v !== 32'h8000_0028) begin errors++; $display("FAIL exc_cause: got %h expected 80000028", v); end
        rd(5'd12, v);
        checks++;
        if (v !== 32'h0000_0002) begin errors++; $display("FAIL exc_sr: got %h expected 00000002", v); end
        pulse_eret();
        rd(5'd12, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL exc_eret_sr: got %h expected 00000000", v); end
    endtask

    task automatic test_no_forward();
        logic [31:0] v;
        addr  = 5'd14;
        wdata = 32'h1234_5678;
        we    = 1'b1;
        #1;
        checks++;
        if (rdata !== 32'h300C) begin errors++; $display("FAIL no_forward: got %h expected 0000300c", rdata); end
        @(posedge clk);
        #1;
        we = 1'b0;
        checks++;
        if (epc_out !== 32'h1234_5678) begin errors++; $display("FAIL epc_write: got %h expected 12345678", epc_out); end
        wr(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, v);
        checks++;
        if (v !== 32'h8000_0028) begin errors++; $display("FAIL cause_readonly: got %h expected 80000028", v); end
    endtask

    task automatic test_simultaneous_and_exl();
        logic [31:0] v;
        wr(5'd12, 32'h0000_0401);
        hwint       = 6'd1;
        exc_code_in = 5'd4;
        vpc         = 32'h3020;
        bd_in       = 1'b0;
        addr        = 5'd14;
        wdata       = 32'hDEAD_BEEF;
        we          = 1'b1;
        #1;
        checks++;
        if (req !== 1'b1) begin errors++; $display("FAIL sim_req: got %b expected 1", req); end
        @(posedge clk);
        #1;
        we          = 1'b0;
        exc_code_in = 5'd0;
        checks++;
        if (epc_out !== 32'h3020) begin errors++; $display("FAIL sim_epc_write_dropped: got %h expected 00003020", epc_out); end
        rd(5'd13, v);
        checks++;
        if (v !== 32'h0000_0400) begin errors++; $display("FAIL sim_exccode: got %h expected 00000400", v); end
        // EXL=1 masks both interrupts and exceptions
        exc_code_in = 5'd12;
        #1;
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL exl_mask_req: got %b expected 0", req); end
        @(posedge clk);
        #1;
        checks++;
        if (epc_out !== 32'h3020) begin errors++; $display("FAIL exl_epc_hold: got %h expected 00003020", epc_out); end
        exc_code_in = 5'd0;
        eret        = 1'b1;
        #1;
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL eret_cycle_req: got %b expected 0", req); end
        @(posedge clk);
        #1;
        eret = 1'b0;
        checks++;
        if (req !== 1'b1) begin errors++; $display("FAIL eret_reint_req: got %b expected 1", req); end
        rd(5'd12, v);
        checks++;
        if (v !== 32'h0000_0401) begin errors++; $display("FAIL eret_sr: got %h expected 00000401", v); end
        hwint = 6'd0;
        #1;
        pulse_eret();
        rd(5'd12, v);
        checks++;
        if (v !== 32'h0000_0401) begin errors++; $display("FAIL eret_noexl: got %h expected 00000401", v); end
    endtask

    task automatic test_timer();
        logic [31:0] v;
        int n;
        hwint = 6'd0;
        wr(5'd12, 32'h0000_8001);
        wr(5'd11, 32'd5);
        wr(5'd9, 32'd0);
        rd(5'd9, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL count_write: got %h expected 00000000", v); end
        n = 0;
        while (req !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 6) begin errors++; $display("FAIL timer_latency: got %0d cycles expected 6", n); end
        rd(5'd13, v);
        checks++;
        if (v[30] !== 1'b1) begin errors++; $display("FAIL timer_ti_set: got %b expected 1", v[30]); end
        @(posedge clk);
        #1;
        rd(5'd13, v);
        checks++;
        if (v !== 32'h4000_8000) begin errors++; $display("FAIL timer_cause: got %h expected 40008000", v); end
        rd(5'd12, v);
        checks++;
        if (v !== 32'h0000_8003) begin errors++; $display("FAIL timer_sr: got %h expected 00008003", v); end
        wr(5'd11, 32'd100);
        rd(5'd13, v);
        checks++;
        if (v[30] !== 1'b0) begin errors++; $display("FAIL timer_ti_clear: got %b expected 0", v[30]); end
        pulse_eret();
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL timer_no_req: got %b expected 0", req); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] v;
        hwint = 6'd0;
        wr(5'd12, 32'h0000_0403);
        wr(5'd9, 32'h1234);
        rd(5'd9, v);
        checks++;
        if (v !== 32'h1234) begin errors++; $display("FAIL pre_reset_count: got %h expected 00001234", v); end
        hwint = 6'd1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL mreset_req: got %b expected 0", req); end
        rd(5'd12, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL mreset_sr: got %h expected 00000000", v); end
        rd(5'd9, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL mreset_count: got %h expected 00000000", v); end
        rd(5'd11, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL mreset_compare: got %h expected 00000000", v); end
        rd(5'd13, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL mreset_cause: got %h expected 00000000", v); end
        checks++;
        if (epc_out !== 32'h0) begin errors++; $display("FAIL mreset_epc: got %h expected 00000000", epc_out); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        rd(5'd13, v);
        checks++;
        if (v !== 32'h0000_0400) begin errors++; $display("FAIL post_reset_ip: got %h expected 00000400", v); end
        hwint = 6'd0;
    endtask

    initial begin
        reset       = 1'b1;
        we          = 1'b0;
        addr        = 5'd0;
        wdata       = 32'h0;
        vpc         = 32'h0;
        bd_in       = 1'b0;
        exc_code_in = 5'd0;
        hwint       = 6'd0;
        eret        = 1'b0;
        test_reset();
        test_interrupt();
        test_exception();
        test_no_forward();
        test_simultaneous_and_exl();
        test_timer();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
